// File: rtl/bka_selftest_if.sv
// Operand/result bus between the self-test engine and the prefix adder under test.
// master = self-test engine side, slave = adder side.
interface bka_selftest_if #(
    parameter int unsigned N = 64
);
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic [N-1:0] sum;
    logic         cout;

    modport master (output a, output b, output cin, input sum, input cout);
    modport slave  (input a, input b, input cin, output sum, output cout);
endinterface

// File: rtl/bka_selftest.sv
// Built-in self-test engine for the Brent-Kung prefix adder: LFSR operands, bit-serial reference check.
// Optional directed vectors 0..3 when BKA_SELFTEST_DIRECTED_EN is defined.
module bka_selftest #(
    parameter int unsigned N             = 64,
    parameter int unsigned NUM_VECTORS   = 256,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [63:0] SEED          = 64'hACE1_2468_1357_BDF9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    bka_selftest_if.master        bus,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [15:0]           fail_count,
    output logic [15:0]           first_fail_idx
);
    localparam logic [N-1:0] SeedN = N'(SEED);

    typedef enum logic [2:0] {StIdle, StSettle, StCapture, StCheck, StDone} state_e;

    function automatic logic [N-1:0] lfsr_next(input logic [N-1:0] x);
        return {x[N-2:0], x[N-1] ^ x[N-2] ^ x[N-4] ^ x[N-5]};
    endfunction

    state_e       state_q, state_d;
    logic [N-1:0] a_q, b_q, lfsr_a_q, lfsr_b_q;
    logic         cin_q;
    logic [N-1:0] sh_a_q, sh_a_d, sh_b_q, sh_b_d, sh_s_q, sh_s_d;
    logic         c_q, c_d, cout_q, cout_d, err_q, err_d;
    logic [15:0]  bit_q, bit_d, settle_q, settle_d, idx_q, idx_d;
    logic         busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic [15:0]  fail_q, fail_d, first_q, first_d;
    logic         first_load, next_load;
    logic         exp_bit, c_nxt, bit_err, last_bit, vec_err;
    logic [15:0]  fail_new;
    logic [N-1:0] src_a, src_b, ld_a, ld_b, lfsr_a_nxt, lfsr_b_nxt;
    logic         ld_cin;

    assign bus.a          = a_q;
    assign bus.b          = b_q;
    assign bus.cin        = cin_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign fail_count     = fail_q;
    assign first_fail_idx = first_q;

    // Next operand vector; a fresh run restarts the LFSRs from the seed.
    always_comb begin
        src_a      = first_load ? SeedN : lfsr_a_q;
        src_b      = first_load ? ~SeedN : lfsr_b_q;
        ld_a       = src_a;
        ld_b       = src_b;
        lfsr_a_nxt = lfsr_next(src_a);
        lfsr_b_nxt = lfsr_next(src_b);
        ld_cin     = src_a[0] ^ src_b[N-1];
`ifdef BKA_SELFTEST_DIRECTED_EN
        begin
            logic [15:0]  ld_idx;
            logic [N-1:0] p55;
            ld_idx = first_load ? 16'd0 : idx_q + 16'd1;
            for (int i = 0; i < int'(N); i++) p55[i] = (i % 2 == 0);
            if (ld_idx < 16'd4) begin
                // LFSRs hold their seed until the first pseudo-random vector
                lfsr_a_nxt = src_a;
                lfsr_b_nxt = src_b;
                unique case (ld_idx[1:0])
                    2'd0: begin ld_a = '0;   ld_b = '0;                       ld_cin = 1'b0; end
                    2'd1: begin ld_a = '1;   ld_b = {{(N-1){1'b0}}, 1'b1};    ld_cin = 1'b0; end
                    2'd2: begin ld_a = '1;   ld_b = '1;                       ld_cin = 1'b1; end
                    2'd3: begin ld_a = p55;  ld_b = ~p55;                     ld_cin = 1'b1; end
                endcase
            end
        end
`endif
    end

    always_comb begin
        exp_bit  = sh_a_q[0] ^ sh_b_q[0] ^ c_q;
        c_nxt    = (sh_a_q[0] & sh_b_q[0]) | (sh_a_q[0] & c_q) | (sh_b_q[0] & c_q);
        bit_err  = exp_bit != sh_s_q[0];
        last_bit = bit_q == 16'(N - 1);
        vec_err  = err_q | bit_err | (last_bit & (cout_q != c_nxt));
        fail_new = (vec_err && fail_q != 16'hFFFF) ? fail_q + 16'd1 : fail_q;
    end

    always_comb begin
        state_d    = state_q;
        sh_a_d     = sh_a_q;
        sh_b_d     = sh_b_q;
        sh_s_d     = sh_s_q;
        c_d        = c_q;
        cout_d     = cout_q;
        err_d      = err_q;
        bit_d      = bit_q;
        settle_d   = settle_q;
        idx_d      = idx_q;
        busy_d     = busy_q;
        done_d     = done_q;
        pass_d     = pass_q;
        fail_d     = fail_q;
        first_d    = first_q;
        first_load = 1'b0;
        next_load  = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    fail_d     = 16'd0;
                    first_d    = 16'hFFFF;
                    done_d     = 1'b0;
                    pass_d     = 1'b0;
                    busy_d     = 1'b1;
                    idx_d      = 16'd0;
                    settle_d   = 16'd0;
                    first_load = 1'b1;
                    state_d    = StSettle;
                end
            end
            StSettle: begin
                if (settle_q == 16'(SETTLE_CYCLES - 1)) state_d = StCapture;
                else settle_d = settle_q + 16'd1;
            end
            StCapture: begin
                sh_s_d  = bus.sum;
                cout_d  = bus.cout;
                sh_a_d  = a_q;
                sh_b_d  = b_q;
                c_d     = cin_q;
                err_d   = 1'b0;
                bit_d   = 16'd0;
                state_d = StCheck;
            end
            StCheck: begin
                sh_a_d = sh_a_q >> 1;
                sh_b_d = sh_b_q >> 1;
                sh_s_d = sh_s_q >> 1;
                c_d    = c_nxt;
                err_d  = err_q | bit_err;
                bit_d  = bit_q + 16'd1;
                if (last_bit) begin
                    fail_d = fail_new;
                    if (vec_err && first_q == 16'hFFFF) first_d = idx_q;
                    if (idx_q == 16'(NUM_VECTORS - 1)) begin
                        done_d  = 1'b1;
                        pass_d  = fail_new == 16'd0;
                        busy_d  = 1'b0;
                        state_d = StDone;
                    end else begin
                        idx_d     = idx_q + 16'd1;
                        settle_d  = 16'd0;
                        next_load = 1'b1;
                        state_d   = StSettle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            cin_q    <= 1'b0;
            lfsr_a_q <= '0;
            lfsr_b_q <= '0;
            sh_a_q   <= '0;
            sh_b_q   <= '0;
            sh_s_q   <= '0;
            c_q      <= 1'b0;
            cout_q   <= 1'b0;
            err_q    <= 1'b0;
            bit_q    <= 16'd0;
            settle_q <= 16'd0;
            idx_q    <= 16'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            fail_q   <= 16'd0;
            first_q  <= 16'hFFFF;
        end else begin
            state_q  <= state_d;
            sh_a_q   <= sh_a_d;
            sh_b_q   <= sh_b_d;
            sh_s_q   <= sh_s_d;
            c_q      <= c_d;
            cout_q   <= cout_d;
            err_q    <= err_d;
            bit_q    <= bit_d;
            settle_q <= settle_d;
            idx_q    <= idx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            fail_q   <= fail_d;
            first_q  <= first_d;
            if (first_load || next_load) begin
                a_q      <= ld_a;
                b_q      <= ld_b;
                cin_q    <= ld_cin;
                lfsr_a_q <= lfsr_a_nxt;
                lfsr_b_q <= lfsr_b_nxt;
            end
        end
    end
endmodule

// File: doc/bka_selftest.md
# bka_selftest

Synthesizable built-in self-test engine that sits on the far side of the `brent_kung_paralell_prefixAdder` operand/result interface. It drives `a`, `b` and `cin` into the adder and reads back `sum` and `cout`. Each result is checked against a bit-serial reference adder, so no second wide adder is needed. Used for silicon/FPGA bring-up of the prefix adder and as a bench-independent checker.

## Interface
Parameters:
- `N`, 64, operand width; must match the adder; N ≥ 8.
- `NUM_VECTORS`, 256, vectors per run; 1..65535.
- `SETTLE_CYCLES`, 2, cycles allowed for adder propagation after operands change; ≥ 1.
- `SEED`, 64'hACE1_2468_1357_BDF9 (truncated to N bits), LFSR seed; must be nonzero.

Ports (one clock, `clk`; reset `rst` is synchronous and active-high):
- `clk`  in  1  clock.
- `rst`  in  1  synchronous active-high reset.
- `start`  in  1  run request pulse.
- `a`  out  N  adder operand A (registered).
- `b`  out  N  adder operand B (registered).
- `cin`  out  1  adder carry-in (registered).
- `sum`  in  N  adder sum.
- `cout`  in  1  adder carry-out.
- `busy`  out  1  run in progress.
- `done`  out  1  run complete; held.
- `pass`  out  1  valid when `done`; 1 = zero failures.
- `fail_count`  out  16  failing vectors; saturates at 16'hFFFF.
- `first_fail_idx`  out  16  index of first failing vector; 16'hFFFF = none.

## Operation
- **FSM states:** IDLE, SETTLE, CAPTURE, CHECK, DONE.
- **IDLE or DONE, `start`=1:**
  - Clear `fail_count` to 0, set `first_fail_idx` to FFFF, clear `done` and `pass`.
  - Load vector 0 onto `a`/`b`/`cin`.
  - Set `busy`; go to SETTLE.
- **SETTLE:** count SETTLE_CYCLES edges, then go to CAPTURE.
- **CAPTURE (1 edge):**
  - Latch `sum`, `cout`.
  - Copy `a`, `b`, `cin` into shift registers.
  - Reference carry `c` ← `cin`.
  - Go to CHECK.
- **CHECK (N edges, bit i = 0..N-1, LSB first):**
  - Expected bit: `a[i]^b[i]^c`; update `c` ← maj(`a[i]`, `b[i]`, `c`).
  - Accumulate mismatch versus the latched `sum[i]`.
  - On bit N-1, also compare the latched `cout` with the final carry.
- **End of CHECK (last edge):**
  - If any mismatch: increment `fail_count` (saturating); if `first_fail_idx`==FFFF, write the vector index.
  - If index == NUM_VECTORS-1: go to DONE, assert `done`, set `pass`=(`fail_count` after update == 0), clear `busy`.
  - Otherwise: load the next vector and go to SETTLE.
- **Vector generation:**
  - `a` and `b` are independent N-bit Fibonacci LFSRs, shifting left.
  - Feedback bit is `x[N-1]^x[N-2]^x[N-4]^x[N-5]`.
  - `a` is seeded with SEED; `b` is seeded with ~SEED.
  - `cin` = `a[0]^b[N-1]` of the new vector.
- **`start` while `busy`:** ignored.
- **`rst` at any point (including mid-CHECK):**
  - `a`=`b`=0, `cin`=0, `busy`=`done`=`pass`=0, `fail_count`=0, `first_fail_idx`=16'hFFFF, state IDLE.
- **Operand stability:** `a`/`b`/`cin` change only on the vector-load edge and are stable through SETTLE, CAPTURE and CHECK.

## Timing
- Operands update on the `start` edge (vector 0) and on the final CHECK edge (vectors 1+).
- Per vector: SETTLE_CYCLES + 1 + N edges.
- `done` is high 1 + NUM_VECTORS·(SETTLE_CYCLES+1+N) edges after the `start` edge, counting the `start` edge as 1. Defaults: 17153.
- `busy` goes high one cycle after `start` is sampled. It falls on the same edge that `done` rises.
- `pass`, `fail_count` and `first_fail_idx` are final when `done`=1. They are held until `start` or `rst`.

## Configuration
- **`BKA_SELFTEST_DIRECTED_EN` defined:** vectors 0..3 are directed (requires NUM_VECTORS ≥ 4):
  - vector 0: (0, 0, 0)
  - vector 1: (all-ones, 1, 0)
  - vector 2: (all-ones, all-ones, 1)
  - vector 3: (0x55…55, 0xAA…AA, 1)
- **Directed mode, LFSR handling:** the LFSRs start from SEED/~SEED at vector 4 and do not advance during vectors 0..3.
- **Not defined:** all vectors come from the LFSRs, starting with vector 0 = (SEED, ~SEED, derived `cin`).

## Test plan
- Correct adder, defaults, macro defined, `start` pulse → `done` at edge 17153, `pass`=1, `fail_count`=0, `first_fail_idx`=FFFF.
- Wrapper forces `sum[5]`=0, macro defined → `pass`=0, `fail_count`≥1, `first_fail_idx`=2 (vector 2 sum is all-ones).
- Wrapper inverts `cout` → `fail_count`=256, `first_fail_idx`=0, `pass`=0.
- `start` pulsed again mid-run at vector 10 → ignored; run completes at edge 17153 with unchanged results.
- `rst` asserted during CHECK of vector 3 → next cycle: all outputs at reset values, state IDLE; a new `start` runs to completion with `pass`=1.
- After `done`, pulse `start` with the faulty wrapper removed → counters clear, `done` drops, and the second run ends with `pass`=1.
